norm_shift_ctrl: RTL and testbench
==================================

NORM_SHIFT_CTRL -- requirements
Module: norm_shift_ctrl

Interface
REQ-001 Parameter MANT_SIZE, default 24: mantissa width presented for normalization.
REQ-002 Parameter EXP_SIZE, default 8: biased exponent width.
REQ-003 Parameter SHIFT_SIZE, default 5: width of shft output; 2**SHIFT_SIZE > MANT_SIZE-1 is required.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronously released.
REQ-006 in_valid  input  1  upstream holds valid operand.
REQ-007 in_ready  output  1  block accepts operand this cycle.
REQ-008 mant  input  MANT_SIZE  unnormalized magnitude, MSB = hidden-bit position.
REQ-009 exp  input  EXP_SIZE  biased exponent of mant.
REQ-010 sign  input  1  sign, passed through.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream left shifter stage accepts result.
REQ-013 mant_q  output  MANT_SIZE  registered mantissa, drives left shifter data input.
REQ-014 shft  output  SHIFT_SIZE  left-shift amount for the downstream shifter.
REQ-015 arith  output  1  fill bit for the shifter; constant 0.
REQ-016 exp_q  output  EXP_SIZE  adjusted exponent.
REQ-017 sign_q  output  1  registered sign.
REQ-018 zero_q  output  1  mantissa was all zeros.
REQ-019 denorm_q  output  1  shift clamped by exponent; result subnormal.

Function
REQ-020 Two-register pipeline: S1 captures mant/exp/sign plus per-half leading-zero counts; S2 combines into the full count and computes shft/exp_q/flags; outputs are S2 registers.
REQ-021 Latency exactly 2 cycles from accepted transfer (in_valid & in_ready) to out_valid, with no stalls.
REQ-022 Transfer occurs only when valid & ready are both high on a rising edge; an offered input is never dropped.
REQ-023 S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S2 loads.
REQ-024 in_ready = !s1_valid | s2_load; combinational from out_ready is allowed; full throughput of 1 result/cycle when out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, all outputs are held stable.
REQ-026 lzc = count of leading zeros of mant, range 0..MANT_SIZE; all-zero mant gives MANT_SIZE.
REQ-027 Zero case (mant=0): shft=0, exp_q=0, zero_q=1, denorm_q=0.
REQ-028 Normal case (exp > lzc): shft=lzc, exp_q=exp-lzc, denorm_q=0.
REQ-029 Clamped case (exp <= lzc, mant != 0): shft = (exp==0) ? 0 : exp-1, exp_q=0, denorm_q=1.
REQ-030 The shft value is never greater than MANT_SIZE-1; exponent arithmetic is unsigned with no wrap below 0.
REQ-031 mant_q and sign_q equal the input values, unmodified.
REQ-032 arith is tied to 0 at all times, including during reset.

Reset
REQ-033 On rst=0: s1_valid, out_valid <= 0 immediately (asynchronous); shft, exp_q, mant_q, sign_q, zero_q, denorm_q <= 0.
REQ-034 in_ready=0 while rst=0; it becomes 1 on the first clock after release.
REQ-035 Reset asserted mid-stream discards all in-flight operands; no out_valid pulse from pre-reset data after release.

Verification (MANT_SIZE=24, EXP_SIZE=8)
REQ-036 mant=0x800000, exp=100 -> after 2 cycles: shft=0, exp_q=100, zero_q=0, denorm_q=0.
REQ-037 mant=0x000001, exp=100 -> shft=23, exp_q=77, denorm_q=0.
REQ-038 Clamp cases, where lzc=15: mant=0x000100, exp=5 -> shft=4, exp_q=0, denorm_q=1. With exp=0 -> shft=0, denorm_q=1.
REQ-039 mant=0, exp=200 -> shft=0, exp_q=0, zero_q=1.
REQ-040 Stream A,B,C back-to-back with out_ready=0 for 4 cycles:
- A and B are held in the pipeline.
- in_ready=0 while C is offered.
- After out_ready=1, A, B, C emerge in order with none lost or duplicated.
REQ-041 Assert rst=0 asynchronously, between clock edges, with 2 operands in flight -> out_valid falls immediately. After release, out_valid stays 0 until a new operand is accepted, and that operand appears 2 cycles later.

Source files
------------

// File: rtl/norm_shift_ctrl.sv
// Normalization shift controller: finds the leading-zero count of a mantissa and
// produces the left-shift amount, adjusted exponent and zero/subnormal flags.
module norm_shift_ctrl #(
    parameter int MANT_SIZE  = 24,
    parameter int EXP_SIZE   = 8,
    parameter int SHIFT_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_SIZE-1:0]  mant,
    input  logic [EXP_SIZE-1:0]   exp,
    input  logic                  sign,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MANT_SIZE-1:0]  mant_q,
    output logic [SHIFT_SIZE-1:0] shft,
    output logic                  arith,
    output logic [EXP_SIZE-1:0]   exp_q,
    output logic                  sign_q,
    output logic                  zero_q,
    output logic                  denorm_q
);

    localparam int HI_W = MANT_SIZE - MANT_SIZE / 2;
    localparam int LO_W = MANT_SIZE / 2;
    localparam int LZ_W = $clog2(MANT_SIZE + 1);
    localparam int CW   = ((EXP_SIZE > LZ_W) ? EXP_SIZE : LZ_W) + 1;

    function automatic logic [LZ_W-1:0] lz_hi(input logic [HI_W-1:0] v);
        logic [LZ_W-1:0] cnt;
        logic            found;
        cnt   = '0;
        found = 1'b0;
        for (int i = HI_W - 1; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) cnt = cnt + LZ_W'(1);
        end
        return cnt;
    endfunction

    function automatic logic [LZ_W-1:0] lz_lo(input logic [LO_W-1:0] v);
        logic [LZ_W-1:0] cnt;
        logic            found;
        cnt   = '0;
        found = 1'b0;
        for (int i = LO_W - 1; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) cnt = cnt + LZ_W'(1);
        end
        return cnt;
    endfunction

    logic                  rst_done_q, rst_done_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [MANT_SIZE-1:0]  s1_mant_q, s1_mant_d;
    logic [EXP_SIZE-1:0]   s1_exp_q, s1_exp_d;
    logic                  s1_sign_q, s1_sign_d;
    logic [LZ_W-1:0]       s1_lz_hi_q, s1_lz_hi_d;
    logic [LZ_W-1:0]       s1_lz_lo_q, s1_lz_lo_d;
    logic                  out_valid_q, out_valid_d;
    logic [MANT_SIZE-1:0]  mant_d;
    logic [SHIFT_SIZE-1:0] shft_q, shft_d;
    logic [EXP_SIZE-1:0]   exp_d;
    logic                  sign_d, zero_d, denorm_d;

    logic            s1_load, s2_load, accept;
    logic [LZ_W-1:0] lz_full;
    logic [CW-1:0]   exp_ext, lz_ext;

    assign arith     = 1'b0;
    assign out_valid = out_valid_q;
    assign shft      = shft_q;

    always_comb begin
        s2_load  = !out_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        // Held low until the first clock after reset release.
        in_ready = rst_done_q && s1_load;
        accept   = in_valid && in_ready;

        rst_done_d = 1'b1;

        s1_valid_d = s1_load ? accept : s1_valid_q;
        s1_mant_d  = accept ? mant : s1_mant_q;
        s1_exp_d   = accept ? exp : s1_exp_q;
        s1_sign_d  = accept ? sign : s1_sign_q;
        s1_lz_hi_d = accept ? lz_hi(mant[MANT_SIZE-1 -: HI_W]) : s1_lz_hi_q;
        s1_lz_lo_d = accept ? lz_lo(mant[LO_W-1:0]) : s1_lz_lo_q;

        // Low half only matters when the whole upper half is zero.
        lz_full = (s1_lz_hi_q == LZ_W'(HI_W)) ? s1_lz_hi_q + s1_lz_lo_q : s1_lz_hi_q;
        exp_ext = CW'(s1_exp_q);
        lz_ext  = CW'(lz_full);

        out_valid_d = s2_load ? s1_valid_q : out_valid_q;
        mant_d      = mant_q;
        shft_d      = shft_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        denorm_d    = denorm_q;

        if (s2_load && s1_valid_q) begin
            mant_d = s1_mant_q;
            sign_d = s1_sign_q;
            if (s1_mant_q == '0) begin
                shft_d   = '0;
                exp_d    = '0;
                zero_d   = 1'b1;
                denorm_d = 1'b0;
            end else if (exp_ext > lz_ext) begin
                shft_d   = SHIFT_SIZE'(lz_full);
                exp_d    = EXP_SIZE'(exp_ext - lz_ext);
                zero_d   = 1'b0;
                denorm_d = 1'b0;
            end else begin
                // Exponent runs out first: shift only down to the subnormal range.
                shft_d   = (s1_exp_q == '0) ? '0 : SHIFT_SIZE'(exp_ext - CW'(1));
                exp_d    = '0;
                zero_d   = 1'b0;
                denorm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mant_q      <= '0;
            shft_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            denorm_q    <= 1'b0;
        end else begin
            rst_done_q  <= rst_done_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            mant_q      <= mant_d;
            shft_q      <= shft_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            denorm_q    <= denorm_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_mant_q  <= s1_mant_d;
        s1_exp_q   <= s1_exp_d;
        s1_sign_q  <= s1_sign_d;
        s1_lz_hi_q <= s1_lz_hi_d;
        s1_lz_lo_q <= s1_lz_lo_d;
    end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Directed bench for norm_shift_ctrl: reset state, lzc/clamp vectors,
// back-pressure ordering and mid-stream asynchronous reset.
module tb_norm_shift_ctrl;

    logic        clk;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mant_i;
    logic [7:0]  exp_i;
    logic        sign_i;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] mant_q;
    logic [4:0]  shft;
    logic        arith;
    logic [7:0]  exp_q;
    logic        sign_q;
    logic        zero_q;
    logic        denorm_q;

    int n_total = 0;
    int n_bad   = 0;

    norm_shift_ctrl #(.MANT_SIZE(24), .EXP_SIZE(8), .SHIFT_SIZE(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant      (mant_i),
        .exp       (exp_i),
        .sign      (sign_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_q    (mant_q),
        .shft      (shft),
        .arith     (arith),
        .exp_q     (exp_q),
        .sign_q    (sign_q),
        .zero_q    (zero_q),
        .denorm_q  (denorm_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic run_vec(input string tag, input logic [23:0] m, input logic [7:0] e,
                           input logic s, input logic [4:0] e_shft, input logic [7:0] e_exp,
                           input logic e_zero, input logic e_den);
        @(negedge clk);
        mant_i   = m;
        exp_i    = e;
        sign_i   = s;
        in_valid = 1'b1;
        #1 check_eq({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, ".lat"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, ".vld"}, 32'(out_valid), 32'd1);
        check_eq({tag, ".shft"}, 32'(shft), 32'(e_shft));
        check_eq({tag, ".exp"}, 32'(exp_q), 32'(e_exp));
        check_eq({tag, ".zero"}, 32'(zero_q), 32'(e_zero));
        check_eq({tag, ".den"}, 32'(denorm_q), 32'(e_den));
        check_eq({tag, ".mant"}, 32'(mant_q), 32'(m));
        check_eq({tag, ".sign"}, 32'(sign_q), 32'(s));
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mant_i    = '0;
        exp_i     = '0;
        sign_i    = 1'b0;

        #1 rst = 1'b0;
        #1;
        check_eq("rst.vld", 32'(out_valid), 32'd0);
        check_eq("rst.rdy", 32'(in_ready), 32'd0);
        check_eq("rst.arith", 32'(arith), 32'd0);
        check_eq("rst.shft", 32'(shft), 32'd0);
        check_eq("rst.exp", 32'(exp_q), 32'd0);
        check_eq("rst.mant", 32'(mant_q), 32'd0);
        check_eq("rst.flags", 32'({sign_q, zero_q, denorm_q}), 32'd0);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check_eq("rel.rdy0", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("rel.rdy1", 32'(in_ready), 32'd1);

        run_vec("norm_msb", 24'h800000, 8'd100, 1'b0, 5'd0, 8'd100, 1'b0, 1'b0);
        run_vec("norm_lsb", 24'h000001, 8'd100, 1'b1, 5'd23, 8'd77, 1'b0, 1'b0);
        run_vec("clamp5", 24'h000100, 8'd5, 1'b0, 5'd4, 8'd0, 1'b0, 1'b1);
        run_vec("clamp0", 24'h000100, 8'd0, 1'b1, 5'd0, 8'd0, 1'b0, 1'b1);
        run_vec("zero", 24'h000000, 8'd200, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
        run_vec("eq_lzc", 24'h000100, 8'd15, 1'b0, 5'd14, 8'd0, 1'b0, 1'b1);
        run_vec("lzc_p1", 24'h000100, 8'd16, 1'b0, 5'd15, 8'd1, 1'b0, 1'b0);
        run_vec("half_hi", 24'h001000, 8'd50, 1'b0, 5'd11, 8'd39, 1'b0, 1'b0);
        run_vec("half_lo", 24'h000800, 8'd50, 1'b1, 5'd12, 8'd38, 1'b0, 1'b0);

        // Back-pressure: A and B stall inside, C must wait.
        @(negedge clk);
        check_eq("drain", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        mant_i    = 24'h400000;
        exp_i     = 8'd10;
        sign_i    = 1'b0;
        in_valid  = 1'b1;
        #1 check_eq("strA.rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        mant_i = 24'h200000;
        #1 check_eq("strB.rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        mant_i = 24'h100000;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("strC.rdy", 32'(in_ready), 32'd0);
            check_eq("hold.vld", 32'(out_valid), 32'd1);
            check_eq("hold.mant", 32'(mant_q), 32'h400000);
            check_eq("hold.exp", 32'(exp_q), 32'd9);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check_eq("strC.rdy2", 32'(in_ready), 32'd1);
        check_eq("outA.vld", 32'(out_valid), 32'd1);
        check_eq("outA.mant", 32'(mant_q), 32'h400000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("outB.vld", 32'(out_valid), 32'd1);
        check_eq("outB.mant", 32'(mant_q), 32'h200000);
        check_eq("outB.exp", 32'(exp_q), 32'd8);
        @(negedge clk);
        check_eq("outC.vld", 32'(out_valid), 32'd1);
        check_eq("outC.mant", 32'(mant_q), 32'h100000);
        check_eq("outC.exp", 32'(exp_q), 32'd7);
        @(negedge clk);
        check_eq("nodup", 32'(out_valid), 32'd0);

        // Asynchronous reset with two operands in flight.
        @(negedge clk);
        mant_i   = 24'h800000;
        exp_i    = 8'd20;
        in_valid = 1'b1;
        @(negedge clk);
        mant_i = 24'h000001;
        @(posedge clk);
        #2 rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("arst.vld", 32'(out_valid), 32'd0);
        check_eq("arst.rdy", 32'(in_ready), 32'd0);
        check_eq("arst.mant", 32'(mant_q), 32'd0);
        check_eq("arst.arith", 32'(arith), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check_eq("arel.rdy0", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("arel.vld", 32'(out_valid), 32'd0);
        end
        run_vec("post_rst", 24'h000800, 8'd50, 1'b0, 5'd12, 8'd38, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
